// File: rtl/alu_issue_pkg.sv
// Shared constants, FSM encoding and decode legality check for the RV32I ALU issue sequencer.
package alu_issue_pkg;

  localparam int REG_W = 32;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPER = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // Only ADD/SUB and SRL/SRA may carry the alternate funct7; immediate shifts are restricted the same way.
  function automatic logic is_legal(input logic [31:0] w);
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    is_legal = 1'b0;
    if (op == OPC_OP) begin
      is_legal = (f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
    end else if (op == OPC_OPIMM) begin
      case (f3)
        3'b001:  is_legal = (f7 == F7_BASE);
        3'b101:  is_legal = (f7 == F7_BASE) || (f7 == F7_ALT);
        default: is_legal = 1'b1;
      endcase
    end
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 32-entry architectural register file: two operand reads, one debug read, one write; x0 is hardwired zero.
import alu_issue_pkg::*;

module alu_regfile #(
  parameter int W = REG_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [4:0]   i_rs1_addr,
  input  logic [4:0]   i_rs2_addr,
  input  logic [4:0]   i_dbg_addr,
  output logic [W-1:0] o_rs1_data,
  output logic [W-1:0] o_rs2_data,
  output logic [W-1:0] o_dbg_data,
  input  logic         i_we,
  input  logic [4:0]   i_waddr,
  input  logic [W-1:0] i_wdata
);

  logic [W-1:0] r_mem [32];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rs1_data = (i_rs1_addr == 5'd0) ? '0 : r_mem[i_rs1_addr];
  assign o_rs2_data = (i_rs2_addr == 5'd0) ? '0 : r_mem[i_rs2_addr];
  assign o_dbg_data = (i_dbg_addr == 5'd0) ? '0 : r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Issues one OP / OP-IMM instruction at a time to an external combinational ALU and writes the result back.
// instr_valid/instr_ready: a word transfers on a rising edge where both are high; the source holds the word until then.
import alu_issue_pkg::*;

module alu_issue #(
  parameter int register_width = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [31:0]               instr_in,
  output logic [register_width-1:0] aluIn1,
  output logic [register_width-1:0] aluIn2,
  output logic [register_width-1:0] instr,
  output logic [2:0]                funct3,
  output logic [6:0]                funct7,
  output logic [4:0]                shift_amount,
  input  logic [register_width-1:0] aluOut,
  output logic                      wb_valid,
  output logic [4:0]                wb_rd,
  output logic [register_width-1:0] wb_data,
  output logic                      illegal,
  input  logic [4:0]                dbg_addr,
  output logic [register_width-1:0] dbg_data,
  output logic [1:0]                dbg_state
);

  state_t                    r_state;
  state_t                    w_next;
  logic [31:0]               r_ir;
  logic [register_width-1:0] r_alu_in1;
  logic [register_width-1:0] r_alu_in2;
  logic [register_width-1:0] r_instr;
  logic [2:0]                r_funct3;
  logic [6:0]                r_funct7;
  logic [4:0]                r_shamt;
  logic [4:0]                r_wb_rd;
  logic [register_width-1:0] r_wb_data;
  logic                      r_illegal;

  logic                      w_legal;
  logic                      w_is_op;
  logic [register_width-1:0] w_imm;
  logic [6:0]                w_f7_out;
  logic [register_width-1:0] w_rs1_data;
  logic [register_width-1:0] w_rs2_data;
  logic                      w_we;

  assign w_legal = is_legal(r_ir);
  assign w_is_op = (r_ir[6:0] == OPC_OP);
  assign w_imm   = {{(register_width-12){r_ir[31]}}, r_ir[31:20]};
  // funct7 only reaches the ALU for register ops and immediate shifts (funct3 001/101).
  assign w_f7_out = (w_is_op || (r_ir[13:12] == 2'b01)) ? r_ir[31:25] : F7_BASE;
  assign w_we     = (r_state == ST_EXEC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    instr_ready = 1'b0;
    wb_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) w_next = ST_OPER;
      end
      ST_OPER: w_next = w_legal ? ST_EXEC : ST_IDLE;
      ST_EXEC: w_next = ST_WB;
      ST_WB: begin
        wb_valid = 1'b1;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ir      <= '0;
      r_alu_in1 <= '0;
      r_alu_in2 <= '0;
      r_instr   <= '0;
      r_funct3  <= '0;
      r_funct7  <= '0;
      r_shamt   <= '0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      if ((r_state == ST_IDLE) && instr_valid) begin
        r_ir <= instr_in;
      end
      if (r_state == ST_OPER) begin
        if (w_legal) begin
          r_alu_in1 <= w_rs1_data;
          r_alu_in2 <= w_is_op ? w_rs2_data : w_imm;
          r_instr   <= r_ir;
          r_funct3  <= r_ir[14:12];
          r_funct7  <= w_f7_out;
          r_shamt   <= w_is_op ? w_rs2_data[4:0] : r_ir[24:20];
        end else begin
          r_illegal <= 1'b1;
        end
      end
      if (r_state == ST_EXEC) begin
        r_wb_data <= aluOut;
        r_wb_rd   <= r_ir[11:7];
      end
    end
  end

  alu_regfile #(.W(register_width)) u_regfile (
    .clk        (clk),
    .reset      (reset),
    .i_rs1_addr (r_ir[19:15]),
    .i_rs2_addr (r_ir[24:20]),
    .i_dbg_addr (dbg_addr),
    .o_rs1_data (w_rs1_data),
    .o_rs2_data (w_rs2_data),
    .o_dbg_data (dbg_data),
    .i_we       (w_we),
    .i_waddr    (r_ir[11:7]),
    .i_wdata    (aluOut)
  );

  assign aluIn1       = r_alu_in1;
  assign aluIn2       = r_alu_in2;
  assign instr        = r_instr;
  assign funct3       = r_funct3;
  assign funct7       = r_funct7;
  assign shift_amount = r_shamt;
  assign wb_rd        = r_wb_rd;
  assign wb_data      = r_wb_data;
  assign illegal      = r_illegal;
  assign dbg_state    = r_state;

endmodule
